// File: rtl/audio_dac_serializer.sv
// I2S DAC-side serializer: buffers stereo frames in a small FIFO and shifts them
// MSB-first onto AUD_DACDAT, following codec-mastered BCLK/LRCK.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  clear_audio_out_memory,
  input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
  input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
  input  logic                  write_audio_out,
  output logic                  audio_out_allowed,
  output logic [CNT_W-1:0]      fifo_used,
  output logic                  underflow,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BC_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEFT_ARM,
    LEFT,
    RIGHT_ARM,
    RIGHT
  } state_t;

  // [0]/[1] synchronizer, [2] history for edge detection
  logic [2:0] bclk_q;
  logic [2:0] lrck_q;
  logic       bclk_fall;
  logic       lrck_fall;
  logic       lrck_rise;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bclk_q <= '0;
      lrck_q <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], AUD_BCLK};
      lrck_q <= {lrck_q[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall = bclk_q[2] & ~bclk_q[1];
  assign lrck_fall = lrck_q[2] & ~lrck_q[1];
  assign lrck_rise = ~lrck_q[2] & lrck_q[1];

  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    fifo_empty;
  logic                    pop_req;
  logic                    pop;
  logic                    push;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign fifo_empty        = (cnt_q == '0);
  assign audio_out_allowed = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign fifo_used         = cnt_q;
  assign pop               = pop_req & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign push              = write_audio_out & (audio_out_allowed | pop);
  assign rd_data           = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_audio_out_memory) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push && !clear_audio_out_memory) begin
      mem_q[wr_ptr_q] <= {left_channel_audio_out, right_channel_audio_out};
    end
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [BC_W-1:0]       bitcnt_q, bitcnt_d;
  logic                  dac_q, dac_d;
  logic                  underflow_q, underflow_d;

  // Next serial bit; counter saturation forces zeros once the word is exhausted
  logic                  emit_dat;
  logic [DATA_WIDTH-1:0] emit_shift;
  logic [BC_W-1:0]       emit_cnt;

  always_comb begin
    emit_dat   = 1'b0;
    emit_shift = shift_q;
    emit_cnt   = bitcnt_q;
    if (bitcnt_q < BC_W'(DATA_WIDTH)) begin
      emit_dat   = shift_q[DATA_WIDTH-1];
      emit_shift = {shift_q[DATA_WIDTH-2:0], 1'b0};
      emit_cnt   = bitcnt_q + BC_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    bitcnt_d    = bitcnt_q;
    dac_d       = dac_q;
    underflow_d = underflow_q;
    pop_req     = 1'b0;

    // An LRCK edge swallows any coincident BCLK fall: that is the I2S one-bit delay
    if ((state_q == WAIT_SYNC || state_q == RIGHT) && lrck_fall) begin
      pop_req  = 1'b1;
      bitcnt_d = '0;
      state_d  = LEFT_ARM;
      if (fifo_empty) begin
        shift_d     = '0;
        hold_d      = '0;
        underflow_d = 1'b1;
      end else begin
        shift_d = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
        hold_d  = rd_data[DATA_WIDTH-1:0];
      end
    end else begin
      case (state_q)
        WAIT_SYNC: dac_d = 1'b0;
        LEFT_ARM, RIGHT_ARM: begin
          if (bclk_fall) begin
            dac_d    = emit_dat;
            shift_d  = emit_shift;
            bitcnt_d = emit_cnt;
            state_d  = (state_q == LEFT_ARM) ? LEFT : RIGHT;
          end
        end
        LEFT: begin
          if (lrck_rise) begin
            shift_d  = hold_q;
            bitcnt_d = '0;
            state_d  = RIGHT_ARM;
          end else if (bclk_fall) begin
            dac_d    = emit_dat;
            shift_d  = emit_shift;
            bitcnt_d = emit_cnt;
          end
        end
        RIGHT: begin
          if (bclk_fall) begin
            dac_d    = emit_dat;
            shift_d  = emit_shift;
            bitcnt_d = emit_cnt;
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= WAIT_SYNC;
      shift_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      dac_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      dac_q       <= dac_d;
      underflow_q <= underflow_d;
    end
  end

  assign AUD_DACDAT = dac_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: drives a codec-style BCLK/LRCK and
// reassembles the serial words from AUD_DACDAT.
module tb_audio_dac_serializer;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        clear_audio_out_memory;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;
  logic        audio_out_allowed;
  logic [2:0]  fifo_used;
  logic        underflow;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_dac_serializer #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4),
    .CNT_W(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .clear_audio_out_memory(clear_audio_out_memory),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out(write_audio_out),
    .audio_out_allowed(audio_out_allowed),
    .fifo_used(fifo_used),
    .underflow(underflow),
    .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // LRCK moves on the same BCLK fall that would carry a word's LSB, so a
  // 32-BCLK slot delivers bits [31:1]; the LSB is dropped at the LRCK edge.
  function automatic logic [30:0] top31(input logic [31:0] w);
    return w[31:1];
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    step(3);
    resetn = 1'b1;
    step(1);
  endtask

  task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
    left_channel_audio_out  = l;
    right_channel_audio_out = r;
    write_audio_out         = 1'b1;
    step(1);
    write_audio_out         = 1'b0;
  endtask

  // One full stereo frame: 32 BCLK periods (16 clocks each) per half, LRCK
  // toggling with the first BCLK fall of each half. Bits are sampled 6 clocks
  // after each fall.
  task automatic run_frame(input logic do_push, input logic [63:0] pdata,
                           input int clr_bit, input int rst_bit,
                           output logic [30:0] lb, output logic [30:0] rb);
    lb = '0;
    rb = '0;
    for (int h = 0; h < 2; h++) begin
      for (int b = 0; b < 32; b++) begin
        AUD_BCLK = 1'b0;
        if (b == 0) AUD_DACLRCK = (h == 1);
        for (int c = 1; c <= 6; c++) begin
          step(1);
          if (h == 0 && b == 0 && do_push) begin
            if (c == 2) begin
              {left_channel_audio_out, right_channel_audio_out} = pdata;
              write_audio_out = 1'b1;
            end
            if (c == 3) begin
              write_audio_out = 1'b0;
              check_eq("push_with_pop_used", 64'(fifo_used), 64'd4);
            end
          end
          if (h == 0 && b == clr_bit) begin
            if (c == 2) begin
              check_eq("used_before_clear", 64'(fifo_used), 64'd3);
              clear_audio_out_memory = 1'b1;
              write_audio_out        = 1'b1;
            end
            if (c == 3) begin
              clear_audio_out_memory = 1'b0;
              write_audio_out        = 1'b0;
              check_eq("used_after_clear", 64'(fifo_used), 64'd0);
            end
          end
        end
        if (b > 0) begin
          if (h == 0) lb[31-b] = AUD_DACDAT;
          else        rb[31-b] = AUD_DACDAT;
        end
        if (h == 0 && b == rst_bit) begin
          check_eq("dacdat_before_reset", 64'(AUD_DACDAT), 64'd1);
          check_eq("used_before_reset", 64'(fifo_used), 64'd1);
          resetn = 1'b0;
          #1;
          check_eq("dacdat_in_reset", 64'(AUD_DACDAT), 64'd0);
          check_eq("used_in_reset", 64'(fifo_used), 64'd0);
          check_eq("allowed_in_reset", 64'(audio_out_allowed), 64'd1);
          step(1);
          resetn = 1'b1;
          step(1);
        end else begin
          step(2);
        end
        AUD_BCLK = 1'b1;
        step(8);
      end
    end
  endtask

  logic [30:0] lb, rb;
  logic [31:0] fl [5];
  logic [31:0] fr [5];

  initial begin
    resetn                  = 1'b0;
    clear_audio_out_memory  = 1'b0;
    left_channel_audio_out  = '0;
    right_channel_audio_out = '0;
    write_audio_out         = 1'b0;
    AUD_BCLK                = 1'b1;
    AUD_DACLRCK             = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fl[i] = {8'hC0 + 8'(i), 24'h5A5A5A};
      fr[i] = {8'h30 + 8'(i), 24'hA5A5A5};
    end

    do_reset();
    check_eq("rst_used", 64'(fifo_used), 64'd0);
    check_eq("rst_allowed", 64'(audio_out_allowed), 64'd1);
    check_eq("rst_underflow", 64'(underflow), 64'd0);
    check_eq("rst_dacdat", 64'(AUD_DACDAT), 64'd0);

    // Single frame through the full path
    push_frame(32'hA5000001, 32'h0000FFFF);
    check_eq("t1_used", 64'(fifo_used), 64'd1);
    run_frame(1'b0, '0, -1, -1, lb, rb);
    check_eq("t1_left", 64'(lb), 64'(top31(32'hA5000001)));
    check_eq("t1_right", 64'(rb), 64'(top31(32'h0000FFFF)));
    check_eq("t1_underflow", 64'(underflow), 64'd0);

    // Five back-to-back writes with BCLK idle: only four fit
    for (int i = 0; i < 5; i++) begin
      left_channel_audio_out  = fl[i];
      right_channel_audio_out = fr[i];
      write_audio_out         = 1'b1;
      check_eq("t2_allowed", 64'(audio_out_allowed), (i < 4) ? 64'd1 : 64'd0);
      step(1);
    end
    write_audio_out = 1'b0;
    check_eq("t2_used_full", 64'(fifo_used), 64'd4);
    check_eq("t2_allowed_full", 64'(audio_out_allowed), 64'd0);

    // Push coinciding with the pop while full, then drain in order
    run_frame(1'b1, {32'hDEADBEEF, 32'hCAFEF00D}, -1, -1, lb, rb);
    check_eq("t4_left0", 64'(lb), 64'(top31(fl[0])));
    check_eq("t4_right0", 64'(rb), 64'(top31(fr[0])));
    for (int i = 1; i < 4; i++) begin
      run_frame(1'b0, '0, -1, -1, lb, rb);
      check_eq("t2_left", 64'(lb), 64'(top31(fl[i])));
      check_eq("t2_right", 64'(rb), 64'(top31(fr[i])));
    end
    run_frame(1'b0, '0, -1, -1, lb, rb);
    check_eq("t4_left_late", 64'(lb), 64'(top31(32'hDEADBEEF)));
    check_eq("t4_right_late", 64'(rb), 64'(top31(32'hCAFEF00D)));
    check_eq("t2_underflow", 64'(underflow), 64'd0);
    check_eq("t2_used_drained", 64'(fifo_used), 64'd0);

    // Flush with three frames queued behind the one on the wire
    push_frame(32'h8000_00F0, 32'hF000_000E);
    push_frame(32'h1111_1111, 32'h2222_2222);
    push_frame(32'h3333_3333, 32'h4444_4444);
    push_frame(32'h5555_5555, 32'h6666_6666);
    run_frame(1'b0, '0, 10, -1, lb, rb);
    check_eq("t5_left_cur", 64'(lb), 64'(top31(32'h8000_00F0)));
    check_eq("t5_right_cur", 64'(rb), 64'(top31(32'hF000_000E)));
    check_eq("t5_underflow_kept", 64'(underflow), 64'd0);
    run_frame(1'b0, '0, -1, -1, lb, rb);
    check_eq("t5_left_zero", 64'(lb), 64'd0);
    check_eq("t5_right_zero", 64'(rb), 64'd0);
    check_eq("t5_underflow", 64'(underflow), 64'd1);

    // Empty FIFO from a fresh reset; underflow is sticky
    do_reset();
    check_eq("t3_underflow_rst", 64'(underflow), 64'd0);
    run_frame(1'b0, '0, -1, -1, lb, rb);
    check_eq("t3_left_zero", 64'(lb), 64'd0);
    check_eq("t3_right_zero", 64'(rb), 64'd0);
    check_eq("t3_underflow", 64'(underflow), 64'd1);
    push_frame(32'h0123_4567, 32'h89AB_CDEF);
    check_eq("t3_underflow_sticky", 64'(underflow), 64'd1);
    check_eq("t3_used", 64'(fifo_used), 64'd1);

    // Reset in the middle of a left word
    do_reset();
    push_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_frame(1'b0, '0, -1, 11, lb, rb);
    check_eq("t6_left_cut", 64'(lb), 64'h7FF0_0000);
    check_eq("t6_right_silent", 64'(rb), 64'd0);
    check_eq("t6_used", 64'(fifo_used), 64'd0);
    check_eq("t6_underflow", 64'(underflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Consumer end of the audio-out sample interface: accepts stereo sample pairs via write/allowed handshake, buffers them in a small FIFO, serializes them MSB-first onto AUD_DACDAT in I2S format.
- Codec is bit-clock and LR-clock master; AUD_BCLK/AUD_DACLRCK are inputs, oversampled in the CLOCK_50 domain.
- Sits between the tone/mix logic (sample writer) and the codec DAC pin.

Parameters:
DATA_WIDTH, 32, bits per channel sample on the write side, all serialized.
FIFO_DEPTH, 4, stereo frames buffered (power of 2, >=2).
CNT_W, 3, width of fifo_used (log2(FIFO_DEPTH)+1).

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge.
resetn  in  1  asynchronous active-low reset.
clear_audio_out_memory  in  1  synchronous FIFO flush.
left_channel_audio_out  in  DATA_WIDTH  left sample, signed two's complement.
right_channel_audio_out  in  DATA_WIDTH  right sample.
write_audio_out  in  1  push strobe, one frame per cycle high.
audio_out_allowed  out  1  FIFO not full.
fifo_used  out  CNT_W  frames currently buffered.
underflow  out  1  sticky: a left half-frame started with FIFO empty.
AUD_BCLK  in  1  codec bit clock (async).
AUD_DACLRCK  in  1  codec LR clock (async), low = left.
AUD_DACDAT  out  1  serial data to codec.

Behaviour:
- Reset (resetn=0, async): FIFO empty, fifo_used=0, audio_out_allowed=1, underflow=0, AUD_DACDAT=0, shift reg 0, state WAIT_SYNC. Reset mid-frame abandons the frame; no partial word is resumed.
- Input sync: AUD_BCLK and AUD_DACLRCK each pass a 2-flop synchronizer plus a history flop. bclk_fall = prev 1 & cur 0; lrck_fall/lrck_rise from LRCK history.
- Write side: push when write_audio_out & audio_out_allowed; {left,right} stored as one entry. Write while full ignored, no state change. audio_out_allowed = (fifo_used != FIFO_DEPTH), combinational from count, so a push in the cycle the FIFO becomes full is accepted and allowed drops next cycle.
- Pop: on lrck_fall in states WAIT_SYNC/RIGHT. If non-empty, pop and load left word into shift reg, hold right word in a holding reg. If empty, load zeros for both and set underflow (cleared only by resetn).
- Simultaneous push and pop in same cycle: fifo_used unchanged; push to full FIFO with concurrent pop is accepted.
- clear_audio_out_memory: empties FIFO next cycle, overrides a push the same cycle; does not affect the word being serialized or underflow.
- FSM: WAIT_SYNC -> (lrck_fall) LEFT_ARM; LEFT_ARM -> (bclk_fall) LEFT; LEFT -> (lrck_rise) RIGHT_ARM (loads holding reg into shift reg); RIGHT_ARM -> (bclk_fall) RIGHT; RIGHT -> (lrck_fall, pop as above) LEFT_ARM. WAIT_SYNC ignores lrck_rise.
- I2S one-bit delay: a bclk_fall in the same cycle as the LRCK edge is consumed by the edge and emits nothing. The first subsequent bclk_fall (the *_ARM transition) drives the MSB on AUD_DACDAT. Each further bclk_fall shifts left one bit, shifting in 0. Bit counter saturates at DATA_WIDTH; once all bits have been sent, AUD_DACDAT=0 for the rest of the half-frame.
- Half-frame shorter than DATA_WIDTH BCLKs: remaining bits are discarded at the next LRCK edge.
- AUD_DACDAT is registered and changes only one CLOCK_50 cycle after a detected bclk_fall, or on reset/WAIT_SYNC (0).
- Latency: a sample written into an empty FIFO appears at the next left half-frame; its MSB goes out on the first BCLK fall after the LRCK fall, plus 3 CLOCK_50 cycles of sync delay.

Test Plan:
- Stimulus: reset, BCLK period 16 CLOCK_50 cycles, LRCK toggling every 32 BCLKs. Write L=32'hA5000001, R=32'h0000FFFF. Response: left slot emits A5000001 MSB-first, starting on the 2nd BCLK fall after the LRCK fall; right slot emits 0000FFFF; underflow stays 0.
- Stimulus: with BCLK stopped, write 5 frames back to back. Response: 4 accepted, fifo_used=4, audio_out_allowed=0 from the cycle after the 4th push; 5th ignored. Restart BCLK: the first 4 frames are serialized in order.
- Stimulus: run clocks with FIFO empty. Response: AUD_DACDAT stays 0, underflow=1 after the first LRCK fall; a later write does not clear underflow.
- Stimulus: FIFO full, then push and lrck_fall in the same cycle. Response: push accepted, fifo_used stays 4.
- Stimulus: assert clear_audio_out_memory with 3 frames queued during a left slot. Response: current left/right words finish; fifo_used=0 next cycle; next left slot outputs zeros and underflow=1.
- Stimulus: deassert resetn at bit 10 of a left word. Response: AUD_DACDAT=0 immediately and fifo_used=0. After release, nothing is output until the next LRCK fall.
